// File: rtl/truth_table_pkg.sv
// ============================================================================
// truth_table_pkg : shared types, sizes and helpers for truth_table_sweeper
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package truth_table_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int NVEC       = 8;
  localparam int IDX_W      = 3;
  localparam int SETTLE_MAX = 15;
  localparam int CNT_W      = $clog2(SETTLE_MAX + 1);
  localparam int ERR_W      = 4;

  function automatic logic [ERR_W-1:0] popcount8(input logic [NVEC-1:0] v);
    logic [ERR_W-1:0] n;
    n = '0;
    for (int i = 0; i < NVEC; i++) begin
      n = n + ERR_W'(v[i]);
    end
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/truth_table_sweeper_settle_timer.sv
// ============================================================================
// settle_timer : holds off sampling for SETTLE cycles after each DRIVE entry
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module settle_timer
  import truth_table_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic run,
  output logic expired
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Loaded with SETTLE-1 so that expiry coincides with the last DRIVE cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CNT_W'(SETTLE - 1);
    end else if (run && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = run && (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/truth_table_sweeper.sv
// ============================================================================
// truth_table_sweeper : drives all 8 vectors of a 3-input circuit, captures O,
// compares against a golden table. Option macro: TRUTH_TABLE_ERRCNT_EN (err_cnt)
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module truth_table_sweeper
  import truth_table_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            o_in,
  input  logic [NVEC-1:0] expected,
  output logic            a_out,
  output logic            b_out,
  output logic            c_out,
  output logic            busy,
  output logic            done,
  output logic [NVEC-1:0] table_out,
  output logic            match
`ifdef TRUTH_TABLE_ERRCNT_EN
  ,
  output logic [ERR_W-1:0] err_cnt
`endif
);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NVEC-1:0]    table_q, table_d;
  logic               match_q, match_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               load;
  logic               expired;
  logic [NVEC-1:0]    table_upd;
  logic               start_acc;
  logic               last_sample;
  logic               final_match;

  settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .run     (state_q == DRIVE),
    .expired (expired)
  );

  always_comb begin
    table_upd        = table_q;
    table_upd[idx_q] = o_in;
  end

  assign start_acc   = (state_q == IDLE) && start;
  assign last_sample = (state_q == SAMPLE) && (idx_q == IDX_W'(NVEC - 1));

`ifdef TRUTH_TABLE_ERRCNT_EN
  logic [ERR_W-1:0] err_q, err_d;
  logic [ERR_W-1:0] final_err;

  assign final_err   = popcount8(table_upd ^ expected);
  assign final_match = (final_err == '0);

  always_comb begin
    err_d = err_q;
    if (start_acc) begin
      err_d = '0;
    end else if (last_sample) begin
      err_d = final_err;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_cnt = err_q;
`else
  assign final_match = (table_upd == expected);
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    table_d = table_q;
    match_d = match_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DRIVE;
          idx_d   = '0;
          table_d = '0;
          match_d = 1'b0;
          load    = 1'b1;
        end
      end
      DRIVE: begin
        if (expired) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        table_d = table_upd;
        if (last_sample) begin
          match_d = final_match;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = DRIVE;
          load    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      table_q <= '0;
      match_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      table_q <= table_d;
      match_q <= match_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // The stimulus is the index itself; it only moves on start or SAMPLE exit.
  assign {a_out, b_out, c_out} = idx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign table_out = table_q;
  assign match     = match_q;

endmodule

`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
// ============================================================================
// tb_truth_table_sweeper : table-driven and directed checks of the sweeper
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_truth_table_sweeper;

  logic       clk = 1'b0;
  logic       rst;
  logic       start1, start3;
  logic [7:0] expected;
  logic [1:0] omode;
  logic       sel;

  logic       a1, b1, c1, busy1, done1, match1;
  logic       a3, b3, c3, busy3, done3, match3;
  logic [7:0] table1, table3;
  logic       o1, o3;
`ifdef TRUTH_TABLE_ERRCNT_EN
  logic [3:0] err1, err3;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  // Circuit under test: O = ((~A|B)&C) ^ ((~B^C)&A)
  function automatic logic cut(input logic [2:0] v);
    return ((~v[2] | v[1]) & v[0]) ^ ((~v[1] ^ v[0]) & v[2]);
  endfunction

  assign o1 = (omode == 2'd1) ? 1'b1 : (omode == 2'd2) ? 1'b0 : cut({a1, b1, c1});
  assign o3 = (omode == 2'd1) ? 1'b1 : (omode == 2'd2) ? 1'b0 : cut({a3, b3, c3});

  truth_table_sweeper #(.SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .o_in(o1), .expected(expected),
    .a_out(a1), .b_out(b1), .c_out(c1), .busy(busy1), .done(done1),
    .table_out(table1), .match(match1)
`ifdef TRUTH_TABLE_ERRCNT_EN
    , .err_cnt(err1)
`endif
  );

  truth_table_sweeper #(.SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .o_in(o3), .expected(expected),
    .a_out(a3), .b_out(b3), .c_out(c3), .busy(busy3), .done(done3),
    .table_out(table3), .match(match3)
`ifdef TRUTH_TABLE_ERRCNT_EN
    , .err_cnt(err3)
`endif
  );

  wire [2:0] t_vec   = sel ? {a3, b3, c3} : {a1, b1, c1};
  wire       t_done  = sel ? done3 : done1;
  wire       t_busy  = sel ? busy3 : busy1;
  wire [7:0] t_table = sel ? table3 : table1;
  wire       t_match = sel ? match3 : match1;
`ifdef TRUTH_TABLE_ERRCNT_EN
  wire [3:0] t_err   = sel ? err3 : err1;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Pulses start on the selected DUT and watches a bounded window of edges.
  task automatic run_sweep(output int lat, output int ndone, output int stim_bad);
    int s;
    s = sel ? 3 : 1;
    @(negedge clk);
    if (sel) start3 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start3 = 1'b0;
    lat = -1;
    ndone = 0;
    stim_bad = 0;
    for (int n = 0; n < 8 * (s + 1) + 6; n++) begin
      if (n > 0) begin
        @(posedge clk);
        #1;
      end
      if (t_done) begin
        ndone++;
        if (lat < 0) lat = n;
      end
      if ((n < 8 * (s + 1)) && (t_vec != 3'(n / (s + 1)))) stim_bad++;
    end
  endtask

  typedef struct {
    logic       sel;
    logic [1:0] omode;
    logic [7:0] exp_in;
    logic [7:0] tab;
    logic       m;
    logic [3:0] err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int lat, ndone, stim_bad, found;

    vecs[0] = '{1'b0, 2'd0, 8'h1A, 8'h1A, 1'b1, 4'd0};
    vecs[1] = '{1'b0, 2'd0, 8'h1B, 8'h1A, 1'b0, 4'd1};
    vecs[2] = '{1'b0, 2'd1, 8'h00, 8'hFF, 1'b0, 4'd8};
    vecs[3] = '{1'b1, 2'd0, 8'h1A, 8'h1A, 1'b1, 4'd0};
    vecs[4] = '{1'b1, 2'd0, 8'hE5, 8'h1A, 1'b0, 4'd8};
    vecs[5] = '{1'b0, 2'd2, 8'h00, 8'h00, 1'b1, 4'd0};

    rst = 1'b1;
    start1 = 1'b0;
    start3 = 1'b0;
    expected = 8'h1A;
    omode = 2'd0;
    sel = 1'b0;

    #2;
    check("reset_dut1", {29'd0, a1, b1, c1, busy1, done1, table1, match1} , 32'd0);
    check("reset_dut3", {29'd0, a3, b3, c3, busy3, done3, table3, match3} , 32'd0);
`ifdef TRUTH_TABLE_ERRCNT_EN
    check("reset_err", {err1, err3}, 32'd0);
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      sel      = vecs[i].sel;
      omode    = vecs[i].omode;
      expected = vecs[i].exp_in;
      run_sweep(lat, ndone, stim_bad);
      check($sformatf("v%0d_latency", i), lat, sel ? 32 : 16);
      check($sformatf("v%0d_done_count", i), ndone, 1);
      check($sformatf("v%0d_stim_order", i), stim_bad, 0);
      check($sformatf("v%0d_table", i), t_table, vecs[i].tab);
      check($sformatf("v%0d_match", i), t_match, vecs[i].m);
      check($sformatf("v%0d_idle", i), t_busy, 1'b0);
`ifdef TRUTH_TABLE_ERRCNT_EN
      check($sformatf("v%0d_err_cnt", i), t_err, vecs[i].err);
`endif
    end

    // start re-pulsed mid-sweep and while in DONE
    sel = 1'b0;
    omode = 2'd0;
    expected = 8'h1A;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    ndone = 0;
    lat = -1;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk);
      #1;
      if (done1) begin
        ndone++;
        if (lat < 0) lat = n;
      end
      start1 = (n == 4) || (n == 16);
    end
    start1 = 1'b0;
    check("repulse_latency", lat, 16);
    check("repulse_done_count", ndone, 1);
    check("repulse_idle", busy1, 1'b0);
    check("repulse_table", table1, 8'h1A);

    // asynchronous reset once vector 4 is on the stimulus
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    found = 0;
    for (int n = 0; n < 40 && found == 0; n++) begin
      if ({a1, b1, c1} == 3'd4) found = 1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check("reach_vec4", found, 1);
    check("busy_before_rst", busy1, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_outputs", {29'd0, a1, b1, c1, busy1, done1, table1, match1}, 32'd0);
`ifdef TRUTH_TABLE_ERRCNT_EN
    check("rst_async_err", err1, 4'd0);
`endif
    ndone = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      if (done1 || busy1) ndone++;
    end
    check("no_done_after_abort", ndone, 0);
    run_sweep(lat, ndone, stim_bad);
    check("post_rst_latency", lat, 16);
    check("post_rst_table", table1, 8'h1A);
    check("post_rst_match", match1, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
